datapath_controller: RTL and testbench

- Multi-cycle control FSM that sits directly upstream of the processor datapath.
- Consumes the datapath's Instruction, Cout and Zout outputs.
- Drives every datapath control strobe plus the memory read/write handshake.
- Sequences fetch, decode and execute, one instruction at a time.

---
 rtl/datapath_controller_pkg.sv | 57 +++++
 rtl/controller_decoder.sv | 110 +++++++++++
 rtl/datapath_controller.sv | 108 ++++++++++
 tb/tb_datapath_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_controller_pkg.sv
// Shared definitions for the datapath controller:
//   - FSM state encoding
//   - opcode constants
//   - multiply-wait counter width
//   - packed bundle of every control strobe the controller drives
package datapath_controller_pkg;

    localparam int MULCNT_W = 4;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC1   = 3'd3,
        ST_MULWAIT = 3'd4,
        ST_MEMRD   = 3'd5,
        ST_MEMWR   = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_HLT = 4'h1;
    localparam logic [3:0] OP_ZST = 4'h2;
    localparam logic [3:0] OP_ZRS = 4'h3;
    localparam logic [3:0] OP_CST = 4'h4;
    localparam logic [3:0] OP_CRS = 4'h5;
    localparam logic [3:0] OP_JMR = 4'h6;
    localparam logic [3:0] OP_BRZ = 4'h7;
    localparam logic [3:0] OP_BRC = 4'h8;
    localparam logic [3:0] OP_ADD = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam logic [3:0] OP_LDA = 4'hB;
    localparam logic [3:0] OP_STA = 4'hC;
    localparam logic [3:0] OP_SHD = 4'hD;

    typedef struct packed {
        logic reset_pc;
        logic pc_plus_i;
        logic pc_plus1;
        logic r_plus_i;
        logic r_plus0;
        logic a_add_b;
        logic a_mul_b;
        logic ir_load;
        logic addr_on_bus;
        logic alu_on_bus;
        logic c_set;
        logic c_reset;
        logic z_set;
        logic z_reset;
        logic shadow;
        logic read_mem;
        logic write_mem;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/controller_decoder.sv
// Purely combinational decoder of the datapath controller.
// Maps the registered state, the current opcode, the status flags and the
// memory handshake to the control strobes and the next state.
// Ports:
//   state        current FSM state
//   opcode       Instruction opcode field
//   cout, zout   datapath carry / zero flags
//   mem_rdy      memory completion for the current request
//   mul_last     multiply counter has reached its final cycle
//   ctrl         all control strobes (default 0)
//   state_nxt    next FSM state
//   illegal_set  undefined opcode seen in DECODE
module controller_decoder
    import datapath_controller_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       cout,
    input  logic       zout,
    input  logic       mem_rdy,
    input  logic       mul_last,
    output ctrl_t      ctrl,
    output state_t     state_nxt,
    output logic       illegal_set
);

    always_comb begin
        ctrl        = '0;
        state_nxt   = state;
        illegal_set = 1'b0;

        case (state)
            ST_RESET: begin
                ctrl.reset_pc = 1'b1;
                state_nxt     = ST_FETCH;
            end

            ST_FETCH: begin
                ctrl.read_mem = 1'b1;
                if (mem_rdy) begin
                    ctrl.ir_load  = 1'b1;
                    ctrl.pc_plus1 = 1'b1;
                    state_nxt     = ST_DECODE;
                end
            end

            ST_DECODE: begin
                case (opcode)
                    OP_NOP:      state_nxt = ST_FETCH;
                    OP_HLT:      state_nxt = ST_HALT;
                    OP_MUL:      state_nxt = ST_MULWAIT;
                    OP_LDA:      state_nxt = ST_MEMRD;
                    OP_STA:      state_nxt = ST_MEMWR;
                    4'hE, 4'hF: begin
                        state_nxt   = ST_HALT;
                        illegal_set = 1'b1;
                    end
                    default:     state_nxt = ST_EXEC1;
                endcase
            end

            ST_EXEC1: begin
                state_nxt = ST_FETCH;
                case (opcode)
                    OP_ZST: ctrl.z_set     = 1'b1;
                    OP_ZRS: ctrl.z_reset   = 1'b1;
                    OP_CST: ctrl.c_set     = 1'b1;
                    OP_CRS: ctrl.c_reset   = 1'b1;
                    OP_JMR: ctrl.pc_plus_i = 1'b1;
                    OP_BRZ: ctrl.pc_plus_i = zout;
                    OP_BRC: ctrl.pc_plus_i = cout;
                    OP_ADD: begin
                        ctrl.a_add_b    = 1'b1;
                        ctrl.alu_on_bus = 1'b1;
                    end
                    OP_SHD: ctrl.shadow    = 1'b1;
                    default: ;
                endcase
            end

            // The product is only driven onto the Databus once the
            // multiplier has been given its full number of cycles.
            ST_MULWAIT: begin
                ctrl.a_mul_b = 1'b1;
                if (mul_last) begin
                    ctrl.alu_on_bus = 1'b1;
                    state_nxt       = ST_FETCH;
                end
            end

            ST_MEMRD: begin
                ctrl.r_plus0  = 1'b1;
                ctrl.read_mem = 1'b1;
                if (mem_rdy) state_nxt = ST_FETCH;
            end

            ST_MEMWR: begin
                ctrl.r_plus_i   = 1'b1;
                ctrl.write_mem  = 1'b1;
                ctrl.alu_on_bus = 1'b1;
                if (mem_rdy) state_nxt = ST_FETCH;
            end

            ST_HALT: ctrl.halted = 1'b1;

            default: state_nxt = ST_RESET;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle fetch/decode/execute controller for the processor datapath.
// Holds the state register, the multiply-wait counter and the sticky
// Illegal flag; the strobes are decoded combinationally from the state.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   Instruction           IR contents; opcode at [OPC_MSB -: 4]
//   Cout, Zout            datapath status flags
//   MemDataReady          memory completion handshake
//   ResetPC .. Shadow     datapath control strobes
//   ReadMem, WriteMem     memory requests, held until MemDataReady
//   Halted, Illegal       halt indication, sticky undefined-opcode flag
// MUL_CYCLES must lie in 1..15 to fit the 4-bit countdown.
module datapath_controller
    import datapath_controller_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int OPC_MSB    = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] Instruction,
    input  logic        Cout,
    input  logic        Zout,
    input  logic        MemDataReady,
    output logic        ResetPC,
    output logic        PCplusI,
    output logic        PCplus1,
    output logic        RplusI,
    output logic        Rplus0,
    output logic        AaddB,
    output logic        AmulB,
    output logic        IRload,
    output logic        Address_on_Databus,
    output logic        ALU_on_Databus,
    output logic        Cset,
    output logic        Creset,
    output logic        Zset,
    output logic        Zreset,
    output logic        Shadow,
    output logic        ReadMem,
    output logic        WriteMem,
    output logic        Halted,
    output logic        Illegal
);

    state_t              state;
    state_t              state_nxt;
    logic [MULCNT_W-1:0] mul_cnt;
    logic                illegal;
    logic                illegal_set;
    logic [3:0]          opcode;
    ctrl_t               ctrl;
    logic                instr_unused;

    assign opcode       = Instruction[OPC_MSB -: 4];
    // Offset bits are consumed by the datapath, not by the controller.
    assign instr_unused = ^Instruction;

    controller_decoder u_controller_decoder (
        .state       (state),
        .opcode      (opcode),
        .cout        (Cout),
        .zout        (Zout),
        .mem_rdy     (MemDataReady),
        .mul_last    (mul_cnt == '0),
        .ctrl        (ctrl),
        .state_nxt   (state_nxt),
        .illegal_set (illegal_set)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_RESET;
            mul_cnt <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            // Loaded with N-1 so that the cycle seeing zero is the Nth one.
            if (state == ST_DECODE && opcode == OP_MUL)
                mul_cnt <= MULCNT_W'(MUL_CYCLES - 1);
            else if (state == ST_MULWAIT && mul_cnt != '0)
                mul_cnt <= mul_cnt - MULCNT_W'(1);
            if (illegal_set)
                illegal <= 1'b1;
        end
    end

    assign ResetPC            = ctrl.reset_pc;
    assign PCplusI            = ctrl.pc_plus_i;
    assign PCplus1            = ctrl.pc_plus1;
    assign RplusI             = ctrl.r_plus_i;
    assign Rplus0             = ctrl.r_plus0;
    assign AaddB              = ctrl.a_add_b;
    assign AmulB              = ctrl.a_mul_b;
    assign IRload             = ctrl.ir_load;
    assign Address_on_Databus = ctrl.addr_on_bus;
    assign ALU_on_Databus     = ctrl.alu_on_bus;
    assign Cset               = ctrl.c_set;
    assign Creset             = ctrl.c_reset;
    assign Zset               = ctrl.z_set;
    assign Zreset             = ctrl.z_reset;
    assign Shadow             = ctrl.shadow;
    assign ReadMem            = ctrl.read_mem;
    assign WriteMem           = ctrl.write_mem;
    assign Halted             = ctrl.halted;
    assign Illegal            = illegal;

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller: an instruction-level model
// predicts every output on each falling clock edge, and directed scenarios
// pin the model with hand-computed counts and values.
module tb_datapath_controller;

    localparam int MULC = 4;

    // Bit positions inside the packed output vector.
    localparam int B_RESETPC = 18, B_PCPI = 17, B_PCP1 = 16, B_RPI = 15, B_RP0 = 14;
    localparam int B_ADD = 13, B_MUL = 12, B_IRL = 11, B_ALU = 9;
    localparam int B_CSET = 8, B_CRST = 7, B_ZSET = 6, B_ZRST = 5, B_SHD = 4;
    localparam int B_RD = 3, B_WR = 2, B_HALT = 1, B_ILL = 0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] Instruction;
    logic        Cout, Zout, MemDataReady;
    logic        ResetPC, PCplusI, PCplus1, RplusI, Rplus0, AaddB, AmulB, IRload;
    logic        Address_on_Databus, ALU_on_Databus, Cset, Creset, Zset, Zreset;
    logic        Shadow, ReadMem, WriteMem, Halted, Illegal;
    logic [18:0] dut_vec;
    logic [18:0] exp_vec;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    datapath_controller #(.MUL_CYCLES(MULC), .OPC_MSB(15)) dut (
        .clk(clk), .reset_n(reset_n), .Instruction(Instruction), .Cout(Cout),
        .Zout(Zout), .MemDataReady(MemDataReady), .ResetPC(ResetPC),
        .PCplusI(PCplusI), .PCplus1(PCplus1), .RplusI(RplusI), .Rplus0(Rplus0),
        .AaddB(AaddB), .AmulB(AmulB), .IRload(IRload),
        .Address_on_Databus(Address_on_Databus), .ALU_on_Databus(ALU_on_Databus),
        .Cset(Cset), .Creset(Creset), .Zset(Zset), .Zreset(Zreset),
        .Shadow(Shadow), .ReadMem(ReadMem), .WriteMem(WriteMem),
        .Halted(Halted), .Illegal(Illegal)
    );

    assign dut_vec = {ResetPC, PCplusI, PCplus1, RplusI, Rplus0, AaddB, AmulB, IRload,
                      Address_on_Databus, ALU_on_Databus, Cset, Creset, Zset, Zreset,
                      Shadow, ReadMem, WriteMem, Halted, Illegal};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // ---------------- instruction-level model ----------------
    // m_step: 0 = fetching, 1 = decoding, 2+ = execution cycle (step-2).
    bit m_rst = 1'b1, m_halt = 1'b0, m_ill = 1'b0;
    int m_step = 0;
    bit n_rst = 1'b1, n_halt = 1'b0, n_ill = 1'b0;
    int n_step = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rst <= 1'b1; m_halt <= 1'b0; m_ill <= 1'b0; m_step <= 0;
        end else begin
            m_rst <= n_rst; m_halt <= n_halt; m_ill <= n_ill; m_step <= n_step;
        end
    end

    always @(negedge clk) begin
        int op;
        int k;
        op = int'(Instruction[15:12]);
        exp_vec = '0;
        n_rst = m_rst; n_halt = m_halt; n_ill = m_ill; n_step = m_step;
        if (!reset_n) begin
            exp_vec[B_RESETPC] = 1'b1;
            n_rst = 1'b1; n_halt = 1'b0; n_ill = 1'b0; n_step = 0;
        end else if (m_rst) begin
            exp_vec[B_RESETPC] = 1'b1;
            n_rst = 1'b0; n_step = 0;
        end else if (m_halt) begin
            exp_vec[B_HALT] = 1'b1;
            exp_vec[B_ILL]  = m_ill;
        end else begin
            exp_vec[B_ILL] = m_ill;
            if (m_step == 0) begin
                exp_vec[B_RD] = 1'b1;
                if (MemDataReady) begin
                    exp_vec[B_IRL]  = 1'b1;
                    exp_vec[B_PCP1] = 1'b1;
                    n_step = 1;
                end
            end else if (m_step == 1) begin
                if (op == 0) n_step = 0;
                else if (op == 1) n_halt = 1'b1;
                else if (op >= 14) begin n_halt = 1'b1; n_ill = 1'b1; end
                else n_step = 2;
            end else begin
                k = m_step - 2;
                n_step = 0;
                case (op)
                    2:  exp_vec[B_ZSET] = 1'b1;
                    3:  exp_vec[B_ZRST] = 1'b1;
                    4:  exp_vec[B_CSET] = 1'b1;
                    5:  exp_vec[B_CRST] = 1'b1;
                    6:  exp_vec[B_PCPI] = 1'b1;
                    7:  exp_vec[B_PCPI] = Zout;
                    8:  exp_vec[B_PCPI] = Cout;
                    9:  begin exp_vec[B_ADD] = 1'b1; exp_vec[B_ALU] = 1'b1; end
                    13: exp_vec[B_SHD] = 1'b1;
                    10: begin
                        exp_vec[B_MUL] = 1'b1;
                        if (k == MULC - 1) exp_vec[B_ALU] = 1'b1;
                        else n_step = m_step + 1;
                    end
                    11: begin
                        exp_vec[B_RP0] = 1'b1; exp_vec[B_RD] = 1'b1;
                        if (!MemDataReady) n_step = m_step;
                    end
                    12: begin
                        exp_vec[B_RPI] = 1'b1; exp_vec[B_WR] = 1'b1; exp_vec[B_ALU] = 1'b1;
                        if (!MemDataReady) n_step = m_step;
                    end
                    default: ;
                endcase
            end
        end
        check("cycle_outputs", 32'(dut_vec), 32'(exp_vec));
    end

    // Wait for the fetch that loads the IR, then present the new
    // instruction and inputs for the cycles that follow.
    task automatic load(input logic [15:0] ins, input logic z, input logic c, input logic m);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = IRload;
            n++;
        end
        if (!seen) check("load_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        Instruction = ins; Zout = z; Cout = c; MemDataReady = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog at %0t: got timeout, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, cnt2, idx;
        logic [15:0] sweep [8];
        reset_n = 1'b0; Instruction = 16'h0000; Cout = 1'b0; Zout = 1'b0; MemDataReady = 1'b1;
        sweep = '{16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h8000, 16'h9000, 16'hD000};

        // Reset state and NOP loop
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resetpc", 32'(ResetPC), 32'd1);
        check("rst_illegal", 32'(Illegal), 32'd0);
        check("rst_readmem", 32'(ReadMem), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_cycle_pc", 32'(ResetPC), 32'd1);
        @(negedge clk);
        check("first_fetch", 32'({IRload, PCplus1, ResetPC}), 32'b110);
        cnt = 0;
        repeat (6) begin @(negedge clk); cnt += int'(IRload); end
        check("nop_loop_irloads", 32'(cnt), 32'd3);
        check("nop_halted", 32'(Halted), 32'd0);

        // Single-cycle execute opcodes
        foreach (sweep[i]) begin
            load(sweep[i], 1'b0, 1'b1, 1'b1);
            repeat (4) @(negedge clk);
        end

        // BRZ taken / not taken
        load(16'h7005, 1'b1, 1'b0, 1'b1);
        cnt = 0;
        repeat (4) begin @(negedge clk); cnt += int'(PCplusI); end
        check("brz_taken", 32'(cnt), 32'd1);
        load(16'h7005, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        repeat (4) begin @(negedge clk); cnt += int'(PCplusI); end
        check("brz_not_taken", 32'(cnt), 32'd0);

        // MUL: idx0 decode, idx1..4 multiply, idx5 fetch
        load(16'hA000, 1'b0, 1'b0, 1'b1);
        cnt = 0; cnt2 = 0; idx = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt  += int'(AmulB);
            cnt2 += int'(ALU_on_Databus);
            if (ALU_on_Databus) idx = i;
            if (i == 5) check("mul_then_fetch", 32'(ReadMem), 32'd1);
        end
        check("mul_amulb_cycles", 32'(cnt), 32'd4);
        check("mul_alu_cycles", 32'(cnt2), 32'd1);
        check("mul_alu_last", 32'(idx), 32'd4);

        // LDA with memory completing on the 4th MEMRD cycle
        load(16'hB010, 1'b0, 1'b0, 1'b0);
        cnt = 0; cnt2 = 0;
        @(negedge clk);
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 4) MemDataReady = 1'b1;
            @(negedge clk);
            cnt  += int'(Rplus0);
            cnt2 += int'(ReadMem);
        end
        check("lda_rplus0_cycles", 32'(cnt), 32'd4);
        check("lda_readmem_cycles", 32'(cnt2), 32'd5);

        // STA aborted by asynchronous reset in its 2nd MEMWR cycle
        load(16'hC000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("sta_writemem", 32'(WriteMem), 32'd1);
        @(posedge clk); #2;
        reset_n = 1'b0; MemDataReady = 1'b1;
        #1;
        check("async_writemem_drop", 32'(WriteMem), 32'd0);
        check("async_resetpc", 32'(ResetPC), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("sta_reset_cycle", 32'(ResetPC), 32'd1);
        @(negedge clk);
        check("sta_refetch", 32'(ReadMem), 32'd1);

        // Undefined opcode halts and stays halted
        load(16'hF000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("ill_flag", 32'(Illegal), 32'd1);
        check("ill_halted", 32'(Halted), 32'd1);
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1 MemDataReady = ~MemDataReady;
            @(negedge clk);
            cnt += int'(|dut_vec[18:2]);
        end
        check("halt_no_strobes", 32'(cnt), 32'd0);
        check("halt_held", 32'(Halted), 32'd1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check("ill_cleared", 32'(Illegal), 32'd0);
        check("halt_cleared", 32'(Halted), 32'd0);
        MemDataReady = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
